// File: rtl/exu_div_iter_pkg.sv
// Shared types and constants for the iterative divider.
package exu_div_iter_pkg;

    localparam int XLEN                = 32;
    localparam int REG_FILE_ADDR_WIDTH = 5;
    localparam int TAG_W               = 4;
    localparam int DIV_CNT_W           = $clog2(XLEN) + 1;

    // Most negative signed value; dividend half of the signed-overflow case.
    localparam logic [XLEN-1:0] XLEN_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_CALC,
        DIV_FIX,
        DIV_DONE
    } div_state_t;

    typedef struct packed {
        logic [XLEN-1:0]                rs1_data;
        logic [XLEN-1:0]                rs2_data;
        logic                           is_signed;
        logic                           is_rem;
        logic [REG_FILE_ADDR_WIDTH-1:0] rd_addr;
        logic [TAG_W-1:0]               instr_tag;
    } div_req_t;

    // Magnitude of an operand; only negates when the operation is signed.
    function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v,
                                                input logic            is_signed);
        return (is_signed && v[XLEN-1]) ? ('0 - v) : v;
    endfunction

endpackage

// File: rtl/exu_div_iter_div_step.sv
// One restoring-division iteration: shift in the next dividend bit and
// subtract the divisor when the partial remainder is large enough.
module exu_div_iter_div_step
    import exu_div_iter_pkg::*;
(
    input  logic [XLEN-1:0] rem_in,
    input  logic            dvd_msb,
    input  logic [XLEN-1:0] dvs,
    output logic [XLEN-1:0] rem_out,
    output logic            q_bit
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    // XLEN+1-bit trial subtract; a clear borrow bit means rem >= dvs.
    always_comb begin
        shifted = {rem_in, dvd_msb};
        diff    = shifted - {1'b0, dvs};
        q_bit   = ~diff[XLEN];
        rem_out = q_bit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    end

endmodule

// File: rtl/exu_div_iter.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
//
// Handshake: start is a strobe, taken only when the unit is IDLE and flush
// is low; while busy is high further starts are dropped. The result is a
// single-cycle wb_valid beat with no backpressure; wb_* hold their last
// value otherwise. flush returns to IDLE on the next edge and masks wb_valid
// in the same cycle.
module exu_div_iter
    import exu_div_iter_pkg::*;
#(
    parameter bit EARLY_OUT_EN = 1'b1
)(
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           start,
    input  logic                           flush,
    input  logic [XLEN-1:0]                rs1_data,
    input  logic [XLEN-1:0]                rs2_data,
    input  logic                           is_signed,
    input  logic                           is_rem,
    input  logic [REG_FILE_ADDR_WIDTH-1:0] rd_addr,
    input  logic [TAG_W-1:0]               instr_tag,
    output logic                           busy,
    output logic                           wb_valid,
    output logic [XLEN-1:0]                wb_data,
    output logic [REG_FILE_ADDR_WIDTH-1:0] wb_rd_addr,
    output logic [TAG_W-1:0]               wb_instr_tag,
    output div_state_t                     dbg_state
);

    div_state_t                     state_q, state_d;
    logic [DIV_CNT_W-1:0]           cnt_q;
    logic [XLEN-1:0]                dvd_q;     // dividend, becomes quotient
    logic [XLEN-1:0]                dvs_q;
    logic [XLEN-1:0]                rem_q;
    logic                           q_neg_q, r_neg_q, is_rem_q, dz_q;
    logic [REG_FILE_ADDR_WIDTH-1:0] rd_q;
    logic [TAG_W-1:0]               tag_q;

    div_req_t        req;
    logic            accept, sign1, sign2, dz, ovf, early;
    logic [XLEN-1:0] early_res, q_fix, r_fix, step_rem;
    logic            step_q;

    exu_div_iter_div_step u_step (
        .rem_in  (rem_q),
        .dvd_msb (dvd_q[XLEN-1]),
        .dvs     (dvs_q),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    // Decode the incoming request and the special cases that bypass iteration.
    always_comb begin
        req       = '{rs1_data, rs2_data, is_signed, is_rem, rd_addr, instr_tag};
        accept    = (state_q == DIV_IDLE) && start && !flush;
        sign1     = req.is_signed && req.rs1_data[XLEN-1];
        sign2     = req.is_signed && req.rs2_data[XLEN-1];
        dz        = (req.rs2_data == '0);
        ovf       = req.is_signed && (req.rs1_data == XLEN_MIN) && (req.rs2_data == '1);
        early     = EARLY_OUT_EN && (dz || ovf);
        early_res = '0;
        if (dz)
            early_res = req.is_rem ? req.rs1_data : {XLEN{1'b1}};
        else
            early_res = req.is_rem ? '0 : XLEN_MIN;
        // Divide-by-zero quotient is forced; the remainder path already
        // reproduces rs1 because its sign follows the dividend.
        q_fix = dz_q ? {XLEN{1'b1}} : (q_neg_q ? ('0 - dvd_q) : dvd_q);
        r_fix = r_neg_q ? ('0 - rem_q) : rem_q;
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= DIV_IDLE;
        else       state_q <= state_d;
    end

    // Next-state and writeback strobe; flush overrides everything.
    always_comb begin
        state_d  = state_q;
        wb_valid = 1'b0;
        if (flush) begin
            state_d = DIV_IDLE;
        end else begin
            case (state_q)
                DIV_IDLE: if (start) state_d = early ? DIV_DONE : DIV_CALC;
                DIV_CALC: if (cnt_q == DIV_CNT_W'(XLEN - 1)) state_d = DIV_FIX;
                DIV_FIX:  state_d = DIV_DONE;
                DIV_DONE: begin
                    state_d  = DIV_IDLE;
                    wb_valid = (wb_rd_addr != '0);
                end
                default:  state_d = DIV_IDLE;
            endcase
        end
    end

    // Operand capture, per-cycle iteration and result registration.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q        <= '0;
            dvd_q        <= '0;
            dvs_q        <= '0;
            rem_q        <= '0;
            q_neg_q      <= 1'b0;
            r_neg_q      <= 1'b0;
            is_rem_q     <= 1'b0;
            dz_q         <= 1'b0;
            rd_q         <= '0;
            tag_q        <= '0;
            wb_data      <= '0;
            wb_rd_addr   <= '0;
            wb_instr_tag <= '0;
        end else if (accept) begin
            cnt_q    <= '0;
            dvd_q    <= abs_val(req.rs1_data, req.is_signed);
            dvs_q    <= abs_val(req.rs2_data, req.is_signed);
            rem_q    <= '0;
            q_neg_q  <= sign1 ^ sign2;
            r_neg_q  <= sign1;
            is_rem_q <= req.is_rem;
            dz_q     <= dz;
            rd_q     <= req.rd_addr;
            tag_q    <= req.instr_tag;
            if (early) begin
                wb_data      <= early_res;
                wb_rd_addr   <= req.rd_addr;
                wb_instr_tag <= req.instr_tag;
            end
        end else if (!flush && state_q == DIV_CALC) begin
            rem_q <= step_rem;
            dvd_q <= {dvd_q[XLEN-2:0], step_q};
            cnt_q <= cnt_q + DIV_CNT_W'(1);
        end else if (!flush && state_q == DIV_FIX) begin
            wb_data      <= is_rem_q ? r_fix : q_fix;
            wb_rd_addr   <= rd_q;
            wb_instr_tag <= tag_q;
        end
    end

    assign busy      = (state_q != DIV_IDLE);
    assign dbg_state = state_q;

    // A start while busy is an issue-side protocol error; it is dropped here.
    cover property (@(posedge clk) disable iff (!rstn) (start && busy));

endmodule

// File: tb/tb_exu_div_iter.sv
// Directed bench for exu_div_iter with an expected-result queue.
module tb_exu_div_iter;
    import exu_div_iter_pkg::*;

    localparam int EXP_W = 32 + TAG_W + REG_FILE_ADDR_WIDTH + XLEN;
    localparam int LAT_N = XLEN + 2;   // start edge -> result sampling edge
    localparam int LAT_E = 1;

    logic                           clk = 1'b0;
    logic                           rstn = 1'b0;
    logic                           start = 1'b0;
    logic                           flush = 1'b0;
    logic [XLEN-1:0]                rs1_data = '0;
    logic [XLEN-1:0]                rs2_data = '0;
    logic                           is_signed = 1'b0;
    logic                           is_rem = 1'b0;
    logic [REG_FILE_ADDR_WIDTH-1:0] rd_addr = '0;
    logic [TAG_W-1:0]               instr_tag = '0;
    logic                           busy, wb_valid;
    logic [XLEN-1:0]                wb_data;
    logic [REG_FILE_ADDR_WIDTH-1:0] wb_rd_addr;
    logic [TAG_W-1:0]               wb_instr_tag;
    div_state_t                     dbg_state;

    logic [EXP_W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    exu_div_iter dut (
        .clk(clk), .rstn(rstn), .start(start), .flush(flush),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .is_signed(is_signed),
        .is_rem(is_rem), .rd_addr(rd_addr), .instr_tag(instr_tag),
        .busy(busy), .wb_valid(wb_valid), .wb_data(wb_data),
        .wb_rd_addr(wb_rd_addr), .wb_instr_tag(wb_instr_tag),
        .dbg_state(dbg_state)
    );

    // Clock and edge counter (cyc == k after the k-th rising edge).
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every writeback beat must match the head of the queue,
    // including the edge at which it is sampled.
    always @(negedge clk) begin
        if (rstn && wb_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_wb: got data=%0h rd=%0d tag=%0d expected no beat (cyc %0d)",
                         wb_data, wb_rd_addr, wb_instr_tag, cyc);
            end else begin
                logic [EXP_W-1:0]               e;
                logic [31:0]                    e_edge;
                logic [TAG_W-1:0]               e_tag;
                logic [REG_FILE_ADDR_WIDTH-1:0] e_rd;
                logic [XLEN-1:0]                e_data;
                e = exp_q.pop_front();
                {e_edge, e_tag, e_rd, e_data} = e;
                check("wb_data", 64'(wb_data), 64'(e_data));
                check("wb_rd_addr", 64'(wb_rd_addr), 64'(e_rd));
                check("wb_instr_tag", 64'(wb_instr_tag), 64'(e_tag));
                check("wb_edge", 64'(cyc + 1), 64'(e_edge));
            end
        end
    end

    // Drive one request; the start edge index is returned in t.
    task automatic issue(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic sg, input logic rm,
                         input logic [REG_FILE_ADDR_WIDTH-1:0] rd,
                         input logic [TAG_W-1:0] tag,
                         input logic [XLEN-1:0] exp_data, input int lat,
                         input bit push, output int t);
        @(negedge clk);
        rs1_data = a; rs2_data = b; is_signed = sg; is_rem = rm;
        rd_addr = rd; instr_tag = tag; start = 1'b1;
        @(posedge clk);
        #1;
        t = cyc;
        start = 1'b0;
        if (push && rd != '0)
            exp_q.push_back({32'(t + lat), tag, rd, exp_data});
    endtask

    // Count consecutive busy-high samples until idle (bounded).
    task automatic busy_len(input string name, input int exp_len);
        int n = 0;
        for (int g = 0; g < 200; g++) begin
            @(negedge clk);
            if (busy) n++;
            else break;
        end
        check(name, 64'(n), 64'(exp_len));
    endtask

    task automatic op(input string name, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                      input logic sg, input logic rm,
                      input logic [REG_FILE_ADDR_WIDTH-1:0] rd,
                      input logic [TAG_W-1:0] tag,
                      input logic [XLEN-1:0] exp_data, input bit early_case);
        int t;
        issue(a, b, sg, rm, rd, tag, exp_data, early_case ? LAT_E : LAT_N, 1'b1, t);
        busy_len(name, early_case ? 1 : LAT_N);
    endtask

    initial begin
        int t, t2;

        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_wb_valid", 64'(wb_valid), 64'(0));
        rstn = 1'b1;
        @(negedge clk);
        check("rst_wb_data", 64'(wb_data), 64'(0));
        check("rst_wb_rd", 64'(wb_rd_addr), 64'(0));
        check("rst_wb_tag", 64'(wb_instr_tag), 64'(0));
        check("rst_state", 64'(dbg_state), 64'(DIV_IDLE));

        // Unsigned and signed normal divides.
        op("divu_100_7",  32'd100, 32'd7, 1'b0, 1'b0, 5'd1, 4'd1, 32'd14, 1'b0);
        op("remu_100_7",  32'd100, 32'd7, 1'b0, 1'b1, 5'd2, 4'd2, 32'd2, 1'b0);
        op("div_m7_2",    32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, 5'd3, 4'd3, 32'hFFFF_FFFD, 1'b0);
        op("rem_m7_2",    32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, 5'd4, 4'd4, 32'hFFFF_FFFF, 1'b0);
        op("div_7_m2",    32'd7, 32'hFFFF_FFFE, 1'b1, 1'b0, 5'd5, 4'd5, 32'hFFFF_FFFD, 1'b0);
        op("rem_7_m2",    32'd7, 32'hFFFF_FFFE, 1'b1, 1'b1, 5'd6, 4'd6, 32'd1, 1'b0);
        op("divu_max_1",  32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 5'd7, 4'd7, 32'hFFFF_FFFF, 1'b0);
        op("divu_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 5'd8, 4'd8, 32'd0, 1'b0);
        op("remu_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 5'd9, 4'd9, 32'h8000_0000, 1'b0);

        // Special cases finish early.
        op("div_by_zero",  32'h1234, 32'd0, 1'b1, 1'b0, 5'd10, 4'd10, 32'hFFFF_FFFF, 1'b1);
        op("remu_by_zero", 32'h1234, 32'd0, 1'b0, 1'b1, 5'd11, 4'd11, 32'h1234, 1'b1);
        op("rem_neg_by_0", 32'hFFFF_FFFB, 32'd0, 1'b1, 1'b1, 5'd12, 4'd12, 32'hFFFF_FFFB, 1'b1);
        op("div_ovf",      32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 5'd13, 4'd13, 32'h8000_0000, 1'b1);
        op("rem_ovf",      32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 5'd14, 4'd14, 32'd0, 1'b1);

        // rd_addr == 0: busy profile unchanged, no beat (monitor flags any).
        op("rd0_busy", 32'd100, 32'd7, 1'b0, 1'b0, 5'd0, 4'd15, 32'd14, 1'b0);

        // Stray start at T+5 is ignored; original result and tag come back.
        issue(32'd100, 32'd7, 1'b0, 1'b0, 5'd17, 4'd5, 32'd14, LAT_N, 1'b1, t);
        repeat (5) @(negedge clk);
        rs1_data = 32'd1000; rs2_data = 32'd10; rd_addr = 5'd18; instr_tag = 4'd9;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        busy_len("stray_start_busy", LAT_N - 5);

        // Flush at T+10 kills the divide; a new one starts at T+11.
        issue(32'hFFFF_FFFF, 32'd3, 1'b0, 1'b0, 5'd19, 4'd6, 32'd0, LAT_N, 1'b0, t);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_busy", 64'(busy), 64'(0));
        issue(32'd9, 32'd3, 1'b0, 1'b0, 5'd20, 4'd7, 32'd3, LAT_N, 1'b1, t2);
        check("flush_restart_edge", 64'(t2 - t), 64'(11));
        busy_len("after_flush_busy", LAT_N);

        // Asynchronous reset in the middle of a divide.
        issue(32'd50, 32'd5, 1'b0, 1'b0, 5'd21, 4'd8, 32'd10, LAT_N, 1'b0, t);
        repeat (3) @(negedge clk);
        #2;
        rstn = 1'b0;
        #1;
        check("async_rst_busy", 64'(busy), 64'(0));
        check("async_rst_wb_data", 64'(wb_data), 64'(0));
        check("async_rst_wb_valid", 64'(wb_valid), 64'(0));
        @(negedge clk);
        rstn = 1'b1;
        repeat (40) @(negedge clk);

        for (int g = 0; g < 100 && exp_q.size() != 0; g++) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
